fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one 36-bit synchronous FIFO (512 deep) among `N_REQ` producers, e.g. ray generators feeding the traversal queue. Each accepted word is tagged with its source index in the upper bits. Multi-word packets hold the grant until `req_last`, and a burst limit prevents any one producer from starving the others. The block sits directly on the FIFO write port and drives `wr_data`/`wr_en` from `full`.

---
 rtl/fifo_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 41 ++++
 rtl/fifo_wr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// ============================================================================
// Module  : fifo_arb_pkg
// Purpose : Shared definitions for the FIFO write arbiter.
//           FIFO_W is the FIFO word width ({tag, payload}).
//           arb_state_e is the arbiter state encoding.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

  localparam int FIFO_W = 36;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Purpose : Combinational cyclic priority picker. It returns the first set
//           request at or after ptr_i, wrapping from N-1 back to 0.
// Ports   : req_i     [N]     request vector
//           ptr_i     [IDX_W] highest-priority index
//           gnt_idx_o [IDX_W] chosen index (0 when nothing is requested)
//           any_o             at least one request is set
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_o
);

  function automatic logic [IDX_W-1:0] wrap_idx(input int a);
    if (a >= N) return IDX_W'(a - N);
    return IDX_W'(a);
  endfunction

  // Scan from the far end toward ptr so that the closest hit wins last.
  always_comb begin
    gnt_idx_o = '0;
    any_o     = |req_i;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[wrap_idx(int'(ptr_i) + k)]) begin
        gnt_idx_o = wrap_idx(int'(ptr_i) + k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module  : fifo_wr_arbiter
// Purpose : Round-robin write arbiter that shares one FIFO write port among
//           N_REQ producers. Each word is tagged with its source index.
//           Multi-word packets hold the grant until req_last_i, or until
//           MAX_BURST words have been written.
// Ports   : clk, rst_n         clock / async active-low reset
//           req_valid_i [N]    word available per requester
//           req_data_i  [N*D]  payloads, requester i at [i*D +: D]
//           req_last_i  [N]    last word of packet
//           req_ready_o [N]    word accepted this cycle
//           fifo_wr_data_o[36] {tag, payload}
//           fifo_wr_en_o       FIFO write strobe
//           fifo_full_i        FIFO full flag
//           grant_id_o         owner (LOCKED) or candidate (IDLE)
//           busy_o             packet lock held
//           burst_cut_o        one-cycle pulse after a forced release
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int TAG_W     = 2,
  parameter int DATA_W    = 34,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ-1:0]        req_last_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [FIFO_W-1:0]       fifo_wr_data_o,
  output logic                    fifo_wr_en_o,
  input  logic                    fifo_full_i,
  output logic [TAG_W-1:0]        grant_id_o,
  output logic                    busy_o,
  output logic                    burst_cut_o
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  // Elaboration-time parameter checks.
  if (TAG_W + DATA_W != FIFO_W) begin : g_bad_width
    $error("fifo_wr_arbiter: TAG_W + DATA_W must equal FIFO_W");
  end
  if (N_REQ < 2 || N_REQ > 16 || TAG_W < $clog2(N_REQ)) begin : g_bad_nreq
    $error("fifo_wr_arbiter: N_REQ out of range or TAG_W too narrow");
  end
  if (MAX_BURST < 1) begin : g_bad_burst
    $error("fifo_wr_arbiter: MAX_BURST must be at least 1");
  end

  arb_state_e       state_q, state_d;
  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic [TAG_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             burst_cut_q, burst_cut_d;

  logic [TAG_W-1:0]  cand;
  logic              any_valid;
  logic [TAG_W-1:0]  sel;
  logic              grant_en;
  logic              xfer;
  logic              sel_last;
  logic [TAG_W-1:0]  sel_inc;
  logic [DATA_W-1:0] data_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign data_arr[i] = req_data_i[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (TAG_W)
  ) u_pick (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .gnt_idx_o (cand),
    .any_o     (any_valid)
  );

  // In LOCKED the owner keeps the port even while its valid is low (bubble).
  assign sel      = (state_q == LOCKED) ? owner_q : cand;
  assign grant_en = (state_q == LOCKED) || any_valid;
  assign xfer     = grant_en && !fifo_full_i && req_valid_i[sel];
  assign sel_last = req_last_i[sel];
  assign sel_inc  = (int'(sel) == N_REQ - 1) ? '0 : sel + 1'b1;

  assign req_ready_o    = (grant_en && !fifo_full_i) ? (N_REQ'(1) << sel) : '0;
  assign fifo_wr_en_o   = xfer;
  assign fifo_wr_data_o = {sel, data_arr[sel]};
  assign grant_id_o     = sel;
  assign busy_o         = (state_q == LOCKED);
  assign burst_cut_o    = burst_cut_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    burst_cut_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (sel_last) begin
            ptr_d = sel_inc;
          end else if (MAX_BURST == 1) begin
            // A one-word burst budget is exhausted by the first word.
            ptr_d       = sel_inc;
            burst_cut_d = 1'b1;
          end else begin
            state_d = LOCKED;
            owner_d = sel;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      LOCKED: begin
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (sel_last) begin
            state_d = IDLE;
            ptr_d   = sel_inc;
            cnt_d   = '0;
          end else if (cnt_q + 1'b1 == CNT_W'(MAX_BURST)) begin
            state_d     = IDLE;
            ptr_d       = sel_inc;
            cnt_d       = '0;
            burst_cut_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      burst_cut_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      burst_cut_q <= burst_cut_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module  : tb_fifo_wr_arbiter
// Purpose : Self-checking bench for fifo_wr_arbiter (N_REQ=4, MAX_BURST=16).
//           Directed stimulus pushes the hand-computed FIFO word for each
//           cycle that must write; a negedge monitor pops and compares.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int TW = 2;
  localparam int DW = 34;
  localparam int MB = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [35:0]     wr_data;
  logic            wr_en;
  logic            fifo_full;
  logic [TW-1:0]   grant_id;
  logic            busy;
  logic            burst_cut;

  int total = 0;
  int bad   = 0;
  logic [35:0] exp_q [$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N_REQ     (N),
    .TAG_W     (TW),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid),
    .req_data_i     (req_data),
    .req_last_i     (req_last),
    .req_ready_o    (req_ready),
    .fifo_wr_data_o (wr_data),
    .fifo_wr_en_o   (wr_en),
    .fifo_full_i    (fifo_full),
    .grant_id_o     (grant_id),
    .busy_o         (busy),
    .burst_cut_o    (burst_cut)
  );

  function automatic logic [DW-1:0] pay(input int i, input int k);
    return DW'(i * 4096 + k);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drv(input int i, input bit v, input bit l, input int k);
    req_valid[i]          = v;
    req_last[i]           = l;
    req_data[i*DW +: DW]  = pay(i, k);
  endtask

  task automatic clr();
    req_valid = '0;
    req_last  = '0;
  endtask

  task automatic push(input int tag, input int k);
    logic [1:0] t;
    t = 2'(tag);
    exp_q.push_back({t, pay(tag, k)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a queued entry means this cycle must write it.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0) begin
        logic [35:0] e;
        e = exp_q.pop_front();
        chk("wr_en", 64'(wr_en), 64'd1);
        chk("wr_data", 64'(wr_data), 64'(e));
      end else if (wr_en) begin
        chk("spurious_wr", 64'(wr_en), 64'd0);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    req_data  = '0;
    clr();
    #12;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_cut", 64'(burst_cut), 0);
    chk("rst_wren", 64'(wr_en), 0);
    chk("rst_ready", 64'(req_ready), 0);
    chk("rst_grant", 64'(grant_id), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin single words: 0,1,2,3,0
    for (int i = 0; i < N; i++) drv(i, 1'b1, 1'b1, 0);
    for (int c = 0; c < 5; c++) begin
      push(c % N, 0);
      #1 chk("rr_grant", 64'(grant_id), 64'(c % N));
      step();
    end
    clr();
    step();

    // Single word from 1 moves ptr to 2
    drv(1, 1'b1, 1'b1, 1);
    push(1, 1);
    step();
    clr();

    // Locked 3-word packet from 2 while 1 and 3 are valid
    for (int w = 0; w < 3; w++) begin
      drv(2, 1'b1, w == 2, w);
      drv(1, 1'b1, 1'b1, 9);
      drv(3, 1'b1, 1'b1, 9);
      push(2, w);
      #1 chk("lock_busy", 64'(busy), 64'(w > 0));
      step();
    end
    drv(2, 1'b0, 1'b0, 0);
    push(3, 9);
    #1 chk("lock_next_grant", 64'(grant_id), 3);
    step();
    clr();

    // Back-pressure mid-packet on requester 0
    drv(0, 1'b1, 1'b0, 0);
    push(0, 0);
    step();
    drv(0, 1'b1, 1'b0, 1);
    drv(1, 1'b1, 1'b1, 5);
    push(0, 1);
    step();
    fifo_full = 1'b1;
    drv(0, 1'b1, 1'b0, 2);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_wren", 64'(wr_en), 0);
      chk("bp_ready", 64'(req_ready), 0);
      chk("bp_busy", 64'(busy), 1);
      chk("bp_owner", 64'(grant_id), 0);
      step();
    end
    fifo_full = 1'b0;
    drv(0, 1'b1, 1'b1, 2);
    push(0, 2);
    #1 chk("bp_resume_ready", 64'(req_ready), 64'b0001);
    step();
    clr();

    // Burst cut: requester 0 streams without last (ptr is now 1)
    drv(0, 1'b1, 1'b0, 1);
    push(0, 1);
    step();
    drv(1, 1'b1, 1'b1, 7);
    for (int k = 2; k <= MB; k++) begin
      drv(0, 1'b1, 1'b0, k);
      push(0, k);
      #1 chk("burst_busy", 64'(busy), 1);
      step();
    end
    drv(0, 1'b1, 1'b0, 17);
    push(1, 7);
    #1;
    chk("cut_pulse", 64'(burst_cut), 1);
    chk("cut_idle", 64'(busy), 0);
    chk("cut_grant", 64'(grant_id), 1);
    step();
    chk("cut_once", 64'(burst_cut), 0);
    chk("resume_grant", 64'(grant_id), 0);
    for (int k = 17; k <= 20; k++) begin
      drv(0, 1'b1, 1'b0, k);
      push(0, k);
      step();
    end

    // Owner bubble: requester 0 idles while 1 and 2 are valid
    drv(0, 1'b0, 1'b0, 0);
    drv(2, 1'b1, 1'b1, 3);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bub_busy", 64'(busy), 1);
      chk("bub_grant", 64'(grant_id), 0);
      chk("bub_wren", 64'(wr_en), 0);
      step();
    end
    drv(0, 1'b1, 1'b0, 21);
    push(0, 21);
    step();

    // Reset mid-packet (cnt is 5 here)
    rst_n = 1'b0;
    clr();
    #1;
    chk("mr_busy", 64'(busy), 0);
    chk("mr_cut", 64'(burst_cut), 0);
    chk("mr_wren", 64'(wr_en), 0);
    chk("mr_ready", 64'(req_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drv(1, 1'b1, 1'b1, 4);
    drv(3, 1'b1, 1'b1, 4);
    push(1, 4);
    #1 chk("mr_first_grant", 64'(grant_id), 1);
    step();
    push(3, 4);
    step();
    clr();
    step();
    step();
    chk("queue_drained", 64'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
